// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Optional status flags are controlled by BARREL_SHIFTER_STATUS_EN (see top).
package shifter_pkg;

    typedef enum logic [1:0] {
        SLL  = 2'b00,
        SRL  = 2'b01,
        SRA  = 2'b10,
        ROTR = 2'b11
    } shift_op_t;

    // Number of set bits in a mask; used to derive pipeline latency.
    function automatic int popcount(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage : shifter_pkg

// File: rtl/shifter_level.sv
// One combinational mux level of the barrel shifter: shifts by SHIFT when en_i is set.
// With BARREL_SHIFTER_STATUS_EN defined it also tracks the last bit shifted out and a zero flag.
module shifter_level
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHIFT = 16
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [1:0]       op_i,
    input  logic             sign_i,
    input  logic             en_i,
`ifdef BARREL_SHIFTER_STATUS_EN
    input  logic             carry_i,
    output logic             carry_o,
    output logic             zero_o,
`endif
    output logic [WIDTH-1:0] data_o
);

    // Upper bits that an arithmetic right shift by SHIFT must fill with the sign.
    localparam logic [WIDTH-1:0] SRA_FILL = ~({WIDTH{1'b1}} >> SHIFT);

    shift_op_t op;
    assign op = shift_op_t'(op_i);

    // Data mux: shift/rotate by this level's distance or pass through.
    always_comb begin
        data_o = data_i;
        if (en_i) begin
            case (op)
                SLL:     data_o = data_i << SHIFT;
                SRL:     data_o = data_i >> SHIFT;
                SRA:     data_o = (data_i >> SHIFT) | (sign_i ? SRA_FILL : '0);
                ROTR:    data_o = (data_i >> SHIFT) | (data_i << (WIDTH - SHIFT));
                default: data_o = data_i;
            endcase
        end
    end

`ifdef BARREL_SHIFTER_STATUS_EN
    // Last bit shifted out: the left-shift loses the bit at WIDTH-SHIFT, right shifts and
    // rotate lose (or wrap to the MSB) the bit at SHIFT-1. Earlier levels' carry passes
    // through when this level is idle.
    always_comb begin
        carry_o = carry_i;
        if (en_i) begin
            if (op == SLL) carry_o = data_i[WIDTH-SHIFT];
            else           carry_o = data_i[SHIFT-1];
        end
    end

    assign zero_o = (data_o == '0);
`endif

endmodule : shifter_level

// File: rtl/pipelined_barrel_shifter.sv
// Parametrised SLL/SRL/SRA/ROTR barrel shifter with optional registers after any mux level.
// Each register stage uses a valid/ready skid-free handshake so bubbles collapse under stall.
// Define BARREL_SHIFTER_STATUS_EN to add the out_carry / out_zero status outputs.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int                 WIDTH     = 32,
    parameter int                 SHAMT_W   = $clog2(WIDTH),
    parameter logic [SHAMT_W-1:0] PIPE_MASK = SHAMT_W'(5'b00100),
    parameter int                 TAG_W     = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag
`ifdef BARREL_SHIFTER_STATUS_EN
    ,
    output logic               out_carry,
    output logic               out_zero
`endif
);

    localparam int LAT = popcount(32'(PIPE_MASK));

    // Index k is the input of mux level k; index SHAMT_W is the output of the whole chain.
    logic               vld_c   [SHAMT_W+1];
    logic               rdy_c   [SHAMT_W+1];
    logic [WIDTH-1:0]   data_c  [SHAMT_W+1];
    logic [SHAMT_W-1:0] shamt_c [SHAMT_W+1];
    logic [1:0]         op_c    [SHAMT_W+1];
    logic [TAG_W-1:0]   tag_c   [SHAMT_W+1];
    logic               sign_c  [SHAMT_W+1];
    logic [WIDTH-1:0]   data_l  [SHAMT_W];
`ifdef BARREL_SHIFTER_STATUS_EN
    logic               carry_c [SHAMT_W+1];
    logic               zero_c  [SHAMT_W+1];
    logic               carry_l [SHAMT_W];
    logic               zero_l  [SHAMT_W];
`endif

    assign vld_c[0]   = in_valid;
    assign data_c[0]  = in_data;
    assign shamt_c[0] = in_shamt;
    assign op_c[0]    = in_op;
    assign tag_c[0]   = in_tag;
    assign sign_c[0]  = in_data[WIDTH-1];
`ifdef BARREL_SHIFTER_STATUS_EN
    assign carry_c[0] = 1'b0;
    assign zero_c[0]  = 1'b0;
`endif

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_level
        shifter_level #(
            .WIDTH (WIDTH),
            .SHIFT (1 << (SHAMT_W - 1 - k))
        ) u_level (
            .data_i  (data_c[k]),
            .op_i    (op_c[k]),
            .sign_i  (sign_c[k]),
            .en_i    (shamt_c[k][SHAMT_W-1-k]),
`ifdef BARREL_SHIFTER_STATUS_EN
            .carry_i (carry_c[k]),
            .carry_o (carry_l[k]),
            .zero_o  (zero_l[k]),
`endif
            .data_o  (data_l[k])
        );

        if (PIPE_MASK[k]) begin : g_reg
            logic               load;
            logic               vld_d;
            logic               vld_q;
            logic [WIDTH-1:0]   data_q;
            logic [SHAMT_W-1:0] shamt_q;
            logic [1:0]         op_q;
            logic [TAG_W-1:0]   tag_q;
            logic               sign_q;
`ifdef BARREL_SHIFTER_STATUS_EN
            logic               carry_q;
            logic               zero_q;
`endif

            // Load when empty or when the downstream side takes our current entry.
            assign load     = !vld_q || rdy_c[k+1];
            assign rdy_c[k] = load;
            assign vld_d    = flush ? 1'b0 : (load ? vld_c[k] : vld_q);

            // Stage valid bit; flush empties the stage on the next edge.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) vld_q <= 1'b0;
                else          vld_q <= vld_d;
            end

            // Stage payload; only captured when a real operation moves in.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    data_q  <= '0;
                    shamt_q <= '0;
                    op_q    <= '0;
                    tag_q   <= '0;
                    sign_q  <= 1'b0;
`ifdef BARREL_SHIFTER_STATUS_EN
                    carry_q <= 1'b0;
                    zero_q  <= 1'b0;
`endif
                end else if (load && vld_c[k]) begin
                    data_q  <= data_l[k];
                    shamt_q <= shamt_c[k];
                    op_q    <= op_c[k];
                    tag_q   <= tag_c[k];
                    sign_q  <= sign_c[k];
`ifdef BARREL_SHIFTER_STATUS_EN
                    carry_q <= carry_l[k];
                    zero_q  <= zero_l[k];
`endif
                end
            end

            assign vld_c[k+1]   = vld_q;
            assign data_c[k+1]  = data_q;
            assign shamt_c[k+1] = shamt_q;
            assign op_c[k+1]    = op_q;
            assign tag_c[k+1]   = tag_q;
            assign sign_c[k+1]  = sign_q;
`ifdef BARREL_SHIFTER_STATUS_EN
            assign carry_c[k+1] = carry_q;
            assign zero_c[k+1]  = zero_q;
`endif
        end else begin : g_wire
            assign rdy_c[k]     = rdy_c[k+1];
            assign vld_c[k+1]   = vld_c[k];
            assign data_c[k+1]  = data_l[k];
            assign shamt_c[k+1] = shamt_c[k];
            assign op_c[k+1]    = op_c[k];
            assign tag_c[k+1]   = tag_c[k];
            assign sign_c[k+1]  = sign_c[k];
`ifdef BARREL_SHIFTER_STATUS_EN
            assign carry_c[k+1] = carry_l[k];
            assign zero_c[k+1]  = zero_l[k];
`endif
        end
    end

    assign rdy_c[SHAMT_W] = out_ready;
    assign out_valid      = vld_c[SHAMT_W];
    assign out_data       = data_c[SHAMT_W];
    assign out_tag        = tag_c[SHAMT_W];
`ifdef BARREL_SHIFTER_STATUS_EN
    assign out_carry      = carry_c[SHAMT_W];
    // A reset/empty pipe may hold zero data; the flag only reports on a live result.
    assign out_zero       = zero_c[SHAMT_W] && vld_c[SHAMT_W];
`endif

    if (LAT == 0) begin : g_comb_ready
        assign in_ready = out_ready;
    end else begin : g_pipe_ready
        assign in_ready = rdy_c[0] && !flush && reset_n;
    end

endmodule : pipelined_barrel_shifter

// File: tb/tb_pipelined_barrel_shifter.sv
`timescale 1ns/1ps
module tb_pipelined_barrel_shifter;
    localparam int W  = 32;
    localparam int SW = 5;
    localparam int TW = 5;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [TW-1:0] tag;
        logic          carry;
        logic          zero;
    } exp_t;
    exp_t sb[$];

    // c_: combinational (mask 0), d_: default mask, f_: fully pipelined
    logic c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [W-1:0] c_in_data, c_out_data;
    logic [SW-1:0] c_in_shamt;
    logic [1:0] c_in_op;
    logic [TW-1:0] c_in_tag, c_out_tag;
    logic d_flush, d_in_valid, d_in_ready, d_out_valid, d_out_ready;
    logic [W-1:0] d_in_data, d_out_data;
    logic [SW-1:0] d_in_shamt;
    logic [1:0] d_in_op;
    logic [TW-1:0] d_in_tag, d_out_tag;
    logic f_flush, f_in_valid, f_in_ready, f_out_valid, f_out_ready;
    logic [W-1:0] f_in_data, f_out_data;
    logic [SW-1:0] f_in_shamt;
    logic [1:0] f_in_op;
    logic [TW-1:0] f_in_tag, f_out_tag;
`ifdef BARREL_SHIFTER_STATUS_EN
    logic c_out_carry, c_out_zero, d_out_carry, d_out_zero, f_out_carry, f_out_zero;
`endif

    pipelined_barrel_shifter #(.WIDTH(W), .PIPE_MASK(5'b00000), .TAG_W(TW)) u_c (
        .clock(clock), .reset_n(reset_n), .flush(c_flush), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .in_data(c_in_data), .in_shamt(c_in_shamt), .in_op(c_in_op),
        .in_tag(c_in_tag), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .out_tag(c_out_tag)
`ifdef BARREL_SHIFTER_STATUS_EN
        , .out_carry(c_out_carry), .out_zero(c_out_zero)
`endif
    );

    pipelined_barrel_shifter #(.WIDTH(W), .PIPE_MASK(5'b00100), .TAG_W(TW)) u_d (
        .clock(clock), .reset_n(reset_n), .flush(d_flush), .in_valid(d_in_valid),
        .in_ready(d_in_ready), .in_data(d_in_data), .in_shamt(d_in_shamt), .in_op(d_in_op),
        .in_tag(d_in_tag), .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out_data(d_out_data), .out_tag(d_out_tag)
`ifdef BARREL_SHIFTER_STATUS_EN
        , .out_carry(d_out_carry), .out_zero(d_out_zero)
`endif
    );

    pipelined_barrel_shifter #(.WIDTH(W), .PIPE_MASK(5'b11111), .TAG_W(TW)) u_f (
        .clock(clock), .reset_n(reset_n), .flush(f_flush), .in_valid(f_in_valid),
        .in_ready(f_in_ready), .in_data(f_in_data), .in_shamt(f_in_shamt), .in_op(f_in_op),
        .in_tag(f_in_tag), .out_valid(f_out_valid), .out_ready(f_out_ready),
        .out_data(f_out_data), .out_tag(f_out_tag)
`ifdef BARREL_SHIFTER_STATUS_EN
        , .out_carry(f_out_carry), .out_zero(f_out_zero)
`endif
    );

    // Reference model
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [SW-1:0] sh,
                                           input logic [1:0] op);
        logic [2*W-1:0] dbl;
        case (op)
            2'b00:   return a << sh;
            2'b01:   return a >> sh;
            2'b10:   return W'($signed(a) >>> sh);
            default: begin
                dbl = {a, a} >> sh;
                return dbl[W-1:0];
            end
        endcase
    endfunction

    function automatic logic model_carry(input logic [W-1:0] a, input logic [SW-1:0] sh,
                                         input logic [1:0] op);
        logic [W-1:0] r;
        int s;
        s = int'(sh);
        if (s == 0) return 1'b0;
        case (op)
            2'b00:   return a[W-s];
            2'b01,
            2'b10:   return a[s-1];
            default: begin
                r = model(a, sh, op);
                return r[W-1];
            end
        endcase
    endfunction

    function automatic exp_t make_exp(input logic [W-1:0] a, input logic [SW-1:0] sh,
                                      input logic [1:0] op, input logic [TW-1:0] tag);
        exp_t e;
        e.data  = model(a, sh, op);
        e.tag   = tag;
        e.carry = model_carry(a, sh, op);
        e.zero  = (e.data == '0);
        return e;
    endfunction

    task automatic test_reset;
        d_in_valid = 1'b1; d_in_data = 32'hFFFF_FFFF; d_in_tag = 5'h1F; d_out_ready = 1'b1;
        f_in_valid = 1'b1; f_in_data = 32'hFFFF_FFFF; f_in_tag = 5'h1F; f_out_ready = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        checks++; if (d_out_valid !== 1'b0) begin failures++; $display("FAIL reset_d_out_valid got=%b exp=0", d_out_valid); end
        checks++; if (d_out_data !== '0) begin failures++; $display("FAIL reset_d_out_data got=%h exp=0", d_out_data); end
        checks++; if (d_out_tag !== '0) begin failures++; $display("FAIL reset_d_out_tag got=%h exp=0", d_out_tag); end
        checks++; if (d_in_ready !== 1'b0) begin failures++; $display("FAIL reset_d_in_ready got=%b exp=0", d_in_ready); end
        checks++; if (f_out_valid !== 1'b0) begin failures++; $display("FAIL reset_f_out_valid got=%b exp=0", f_out_valid); end
        checks++; if (f_out_data !== '0) begin failures++; $display("FAIL reset_f_out_data got=%h exp=0", f_out_data); end
        checks++; if (f_out_tag !== '0) begin failures++; $display("FAIL reset_f_out_tag got=%h exp=0", f_out_tag); end
        checks++; if (f_in_ready !== 1'b0) begin failures++; $display("FAIL reset_f_in_ready got=%b exp=0", f_in_ready); end
        d_in_valid = 1'b0;
        f_in_valid = 1'b0;
        @(posedge clock);
        #2 reset_n = 1'b1;
    endtask

    task automatic test_comb;
        logic [W-1:0] exp_tab [4];
        logic [W-1:0] a;
        logic [SW-1:0] sh;
        logic [1:0] op;
        exp_tab = '{32'h0000_0002, 32'h4000_0000, 32'hC000_0000, 32'hC000_0000};
        c_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            c_in_valid = 1'b1; c_in_data = 32'h8000_0001; c_in_shamt = 5'd1;
            c_in_op = 2'(i); c_in_tag = 5'(i + 3);
            #1;
            checks++; if (c_out_data !== exp_tab[i]) begin failures++; $display("FAIL comb_op%0d_data got=%h exp=%h", i, c_out_data, exp_tab[i]); end
            checks++; if (c_out_tag !== 5'(i + 3)) begin failures++; $display("FAIL comb_op%0d_tag got=%h exp=%h", i, c_out_tag, 5'(i + 3)); end
            checks++; if (c_out_valid !== 1'b1) begin failures++; $display("FAIL comb_op%0d_valid got=%b exp=1", i, c_out_valid); end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            c_in_data = 32'hA5A5_1234; c_in_shamt = 5'd0; c_in_op = 2'(i);
            #1;
            checks++; if (c_out_data !== 32'hA5A5_1234) begin failures++; $display("FAIL comb_shamt0_op%0d got=%h exp=a5a51234", i, c_out_data); end
        end
        @(negedge clock);
        c_in_valid = 1'b0; c_out_ready = 1'b0;
        #1;
        checks++; if (c_out_valid !== 1'b0) begin failures++; $display("FAIL comb_valid_pass got=%b exp=0", c_out_valid); end
        checks++; if (c_in_ready !== 1'b0) begin failures++; $display("FAIL comb_ready_pass got=%b exp=0", c_in_ready); end
        c_out_ready = 1'b1; c_in_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clock);
            a = $urandom; sh = 5'($urandom_range(0, 31)); op = 2'($urandom_range(0, 3));
            c_in_data = a; c_in_shamt = sh; c_in_op = op;
            #1;
            checks++; if (c_out_data !== model(a, sh, op)) begin failures++; $display("FAIL comb_rand a=%h sh=%0d op=%0d got=%h exp=%h", a, sh, op, c_out_data, model(a, sh, op)); end
`ifdef BARREL_SHIFTER_STATUS_EN
            checks++; if (c_out_carry !== model_carry(a, sh, op)) begin failures++; $display("FAIL comb_rand_carry a=%h sh=%0d op=%0d got=%b exp=%b", a, sh, op, c_out_carry, model_carry(a, sh, op)); end
`endif
        end
        c_in_valid = 1'b0;
    endtask

`ifdef BARREL_SHIFTER_STATUS_EN
    task automatic test_status;
        c_out_ready = 1'b1;
        @(negedge clock);
        c_in_valid = 1'b1; c_in_data = 32'h8000_0000; c_in_shamt = 5'd1; c_in_op = 2'b00;
        #1;
        checks++; if (c_out_data !== '0) begin failures++; $display("FAIL status_sll_data got=%h exp=0", c_out_data); end
        checks++; if (c_out_carry !== 1'b1) begin failures++; $display("FAIL status_sll_carry got=%b exp=1", c_out_carry); end
        checks++; if (c_out_zero !== 1'b1) begin failures++; $display("FAIL status_sll_zero got=%b exp=1", c_out_zero); end
        @(negedge clock);
        c_in_data = 32'h0000_0001; c_in_shamt = 5'd1; c_in_op = 2'b11;
        #1;
        checks++; if (c_out_data !== 32'h8000_0000) begin failures++; $display("FAIL status_rotr_data got=%h exp=80000000", c_out_data); end
        checks++; if (c_out_carry !== 1'b1) begin failures++; $display("FAIL status_rotr_carry got=%b exp=1", c_out_carry); end
        checks++; if (c_out_zero !== 1'b0) begin failures++; $display("FAIL status_rotr_zero got=%b exp=0", c_out_zero); end
        c_in_valid = 1'b0;
    endtask
`endif

    task automatic test_latency;
        d_out_ready = 1'b1;
        @(negedge clock);
        d_in_valid = 1'b1; d_in_data = 32'hF000_0000; d_in_shamt = 5'd31; d_in_op = 2'b10; d_in_tag = 5'd7;
        #1;
        checks++; if (d_in_ready !== 1'b1) begin failures++; $display("FAIL lat_in_ready got=%b exp=1", d_in_ready); end
        checks++; if (d_out_valid !== 1'b0) begin failures++; $display("FAIL lat_early_valid got=%b exp=0", d_out_valid); end
        @(negedge clock);
        d_in_valid = 1'b0;
        #1;
        checks++; if (d_out_valid !== 1'b1) begin failures++; $display("FAIL lat_valid got=%b exp=1", d_out_valid); end
        checks++; if (d_out_data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL lat_data got=%h exp=ffffffff", d_out_data); end
        checks++; if (d_out_tag !== 5'd7) begin failures++; $display("FAIL lat_tag got=%0d exp=7", d_out_tag); end
`ifdef BARREL_SHIFTER_STATUS_EN
        checks++; if (d_out_carry !== 1'b1) begin failures++; $display("FAIL lat_carry got=%b exp=1", d_out_carry); end
        checks++; if (d_out_zero !== 1'b0) begin failures++; $display("FAIL lat_zero got=%b exp=0", d_out_zero); end
`endif
        @(negedge clock);
        #1;
        checks++; if (d_out_valid !== 1'b0) begin failures++; $display("FAIL lat_no_dup got=%b exp=0", d_out_valid); end
        // Backpressure on the single-stage pipe
        @(negedge clock);
        d_out_ready = 1'b0;
        d_in_valid = 1'b1; d_in_data = 32'h1234_5678; d_in_shamt = 5'd8; d_in_op = 2'b01; d_in_tag = 5'd3;
        #1;
        checks++; if (d_in_ready !== 1'b1) begin failures++; $display("FAIL bp_accept got=%b exp=1", d_in_ready); end
        @(negedge clock);
        d_in_data = 32'hAAAA_0000; d_in_shamt = 5'd4; d_in_op = 2'b00; d_in_tag = 5'd4;
        #1;
        checks++; if (d_in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", d_in_ready); end
        repeat (2) @(negedge clock);
        #1;
        checks++; if (d_out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid got=%b exp=1", d_out_valid); end
        checks++; if (d_out_data !== 32'h0012_3456) begin failures++; $display("FAIL bp_hold_data got=%h exp=00123456", d_out_data); end
        checks++; if (d_out_tag !== 5'd3) begin failures++; $display("FAIL bp_hold_tag got=%0d exp=3", d_out_tag); end
        @(negedge clock);
        d_out_ready = 1'b1;
        #1;
        checks++; if (d_in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", d_in_ready); end
        @(negedge clock);
        d_in_valid = 1'b0;
        #1;
        checks++; if (d_out_data !== 32'hAAA0_0000 || d_out_valid !== 1'b1) begin failures++; $display("FAIL bp_second got=%h/%b exp=aaa00000/1", d_out_data, d_out_valid); end
        checks++; if (d_out_tag !== 5'd4) begin failures++; $display("FAIL bp_second_tag got=%0d exp=4", d_out_tag); end
        @(negedge clock);
        #1;
        checks++; if (d_out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", d_out_valid); end
    endtask

    task automatic test_back_to_back;
        int sent, got, cyc, first_post, last_post, n_post;
        exp_t e;
        sent = 0; got = 0; cyc = 0; first_post = -1; last_post = -1; n_post = 0;
        sb.delete();
        f_flush = 1'b0;
        while ((sent < 8 || got < 8) && cyc < 60) begin
            @(negedge clock);
            f_out_ready = !(cyc >= 3 && cyc <= 6);
            if (sent < 8) begin
                f_in_valid = 1'b1;
                f_in_data  = 32'h1357_9BDF ^ (32'(sent) * 32'h0101_0101);
                f_in_shamt = 5'(sent * 3 + 1);
                f_in_op    = 2'(sent);
                f_in_tag   = 5'(sent + 10);
            end else begin
                f_in_valid = 1'b0;
            end
            #1;
            if (f_in_valid && f_in_ready) begin
                sb.push_back(make_exp(f_in_data, f_in_shamt, f_in_op, f_in_tag));
                sent++;
            end
            if (f_out_valid && f_out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++; $display("FAIL b2b_unexpected got=%h exp=none", f_out_data);
                end else begin
                    e = sb.pop_front();
                    if (f_out_data !== e.data || f_out_tag !== e.tag) begin
                        failures++; $display("FAIL b2b_result got=%h/%0d exp=%h/%0d", f_out_data, f_out_tag, e.data, e.tag);
                    end
                end
                got++;
                if (cyc >= 7) begin
                    if (first_post < 0) first_post = cyc;
                    last_post = cyc;
                    n_post++;
                end
            end
            cyc++;
        end
        f_in_valid = 1'b0;
        checks++; if (got != 8 || sent != 8) begin failures++; $display("FAIL b2b_count got=%0d/%0d exp=8/8", sent, got); end
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL b2b_leftover got=%0d exp=0", sb.size()); end
        checks++; if (n_post == 0 || last_post - first_post + 1 != n_post) begin failures++; $display("FAIL b2b_throughput got=%0d cycles exp=%0d", last_post - first_post + 1, n_post); end
    endtask

    task automatic test_flush;
        int n;
        logic seen;
        f_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            f_in_valid = 1'b1; f_in_data = 32'h0000_1000 + 32'(i); f_in_shamt = 5'd2; f_in_op = 2'b00; f_in_tag = 5'(i + 1);
            #1;
            checks++; if (f_in_ready !== 1'b1) begin failures++; $display("FAIL flush_pre_ready%0d got=%b exp=1", i, f_in_ready); end
        end
        @(negedge clock);
        f_flush = 1'b1; f_in_valid = 1'b1; f_in_data = 32'hDEAD_BEEF; f_in_tag = 5'd21;
        #1;
        checks++; if (f_in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", f_in_ready); end
        @(negedge clock);
        f_flush = 1'b0; f_in_valid = 1'b0;
        #1;
        checks++; if (f_out_valid !== 1'b0) begin failures++; $display("FAIL flush_next_valid got=%b exp=0", f_out_valid); end
        seen = 1'b0;
        repeat (8) begin
            @(negedge clock);
            #1;
            if (f_out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL flush_leak got=%b exp=0", seen); end
        @(negedge clock);
        f_in_valid = 1'b1; f_in_data = 32'h0F0F_00FF; f_in_shamt = 5'd4; f_in_op = 2'b11; f_in_tag = 5'd9;
        #1;
        checks++; if (f_in_ready !== 1'b1) begin failures++; $display("FAIL flush_post_ready got=%b exp=1", f_in_ready); end
        n = 0;
        do begin
            @(negedge clock);
            f_in_valid = 1'b0;
            #1;
            n++;
        end while (!f_out_valid && n < 20);
        checks++; if (f_out_valid !== 1'b1 || n != 5) begin failures++; $display("FAIL flush_post_latency got=%0d exp=5", n); end
        checks++; if (f_out_data !== 32'hF0F0_F00F) begin failures++; $display("FAIL flush_post_data got=%h exp=f0f0f00f", f_out_data); end
        checks++; if (f_out_tag !== 5'd9) begin failures++; $display("FAIL flush_post_tag got=%0d exp=9", f_out_tag); end
        @(negedge clock);
    endtask

    task automatic test_random_stream;
        int sent, got, cyc;
        exp_t e;
        sent = 0; got = 0; cyc = 0;
        sb.delete();
        while ((cyc < 80 || sb.size() != 0) && cyc < 200) begin
            @(negedge clock);
            f_out_ready = (cyc >= 80) ? 1'b1 : ($urandom_range(0, 9) < 6);
            if (!(f_in_valid && !f_in_ready)) begin
                f_in_valid = (cyc < 80) && ($urandom_range(0, 3) != 0);
                f_in_data  = $urandom;
                f_in_shamt = 5'($urandom_range(0, 31));
                f_in_op    = 2'($urandom_range(0, 3));
                f_in_tag   = 5'($urandom_range(0, 31));
            end
            #1;
            if (f_in_valid && f_in_ready) begin
                sb.push_back(make_exp(f_in_data, f_in_shamt, f_in_op, f_in_tag));
                sent++;
            end
            if (f_out_valid && f_out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++; $display("FAIL rand_unexpected got=%h exp=none", f_out_data);
                end else begin
                    e = sb.pop_front();
                    if (f_out_data !== e.data || f_out_tag !== e.tag) begin
                        failures++; $display("FAIL rand_result got=%h/%0d exp=%h/%0d", f_out_data, f_out_tag, e.data, e.tag);
                    end
`ifdef BARREL_SHIFTER_STATUS_EN
                    checks++;
                    if (f_out_carry !== e.carry || f_out_zero !== e.zero) begin
                        failures++; $display("FAIL rand_flags got=%b%b exp=%b%b", f_out_carry, f_out_zero, e.carry, e.zero);
                    end
`endif
                end
                got++;
            end
            cyc++;
        end
        f_in_valid = 1'b0;
        checks++; if (sb.size() != 0 || got != sent) begin failures++; $display("FAIL rand_drain got=%0d exp=%0d", got, sent); end
    endtask

    task automatic test_reset_mid;
        int n;
        f_out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            f_in_valid = 1'b1; f_in_data = 32'h0F00_0000 + 32'(k); f_in_shamt = 5'd1; f_in_op = 2'b00; f_in_tag = 5'(k + 1);
            #1;
            if (!f_in_ready) break;
        end
        checks++; if (f_out_valid !== 1'b1) begin failures++; $display("FAIL rmid_prefill got=%b exp=1", f_out_valid); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (f_out_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", f_out_valid); end
        checks++; if (f_out_data !== '0) begin failures++; $display("FAIL rmid_data got=%h exp=0", f_out_data); end
        checks++; if (f_out_tag !== '0) begin failures++; $display("FAIL rmid_tag got=%h exp=0", f_out_tag); end
        checks++; if (f_in_ready !== 1'b0) begin failures++; $display("FAIL rmid_in_ready got=%b exp=0", f_in_ready); end
        f_in_valid = 1'b0;
        @(posedge clock);
        #2 reset_n = 1'b1;
        @(negedge clock);
        f_out_ready = 1'b1;
        f_in_valid = 1'b1; f_in_data = 32'h8000_00F0; f_in_shamt = 5'd4; f_in_op = 2'b10; f_in_tag = 5'd17;
        #1;
        checks++; if (f_in_ready !== 1'b1) begin failures++; $display("FAIL rmid_resume_ready got=%b exp=1", f_in_ready); end
        n = 0;
        do begin
            @(negedge clock);
            f_in_valid = 1'b0;
            #1;
            n++;
        end while (!f_out_valid && n < 20);
        checks++; if (f_out_valid !== 1'b1 || n != 5) begin failures++; $display("FAIL rmid_latency got=%0d exp=5", n); end
        checks++; if (f_out_data !== 32'hF800_000F) begin failures++; $display("FAIL rmid_data_after got=%h exp=f800000f", f_out_data); end
        checks++; if (f_out_tag !== 5'd17) begin failures++; $display("FAIL rmid_tag_after got=%0d exp=17", f_out_tag); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        c_flush = 1'b0; c_in_valid = 1'b0; c_out_ready = 1'b0; c_in_data = '0; c_in_shamt = '0; c_in_op = '0; c_in_tag = '0;
        d_flush = 1'b0; d_in_valid = 1'b0; d_out_ready = 1'b0; d_in_data = '0; d_in_shamt = '0; d_in_op = '0; d_in_tag = '0;
        f_flush = 1'b0; f_in_valid = 1'b0; f_out_ready = 1'b0; f_in_data = '0; f_in_shamt = '0; f_in_op = '0; f_in_tag = '0;
        test_reset();
        test_comb();
`ifdef BARREL_SHIFTER_STATUS_EN
        test_status();
`endif
        test_latency();
        test_back_to_back();
        test_flush();
        test_random_stream();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipelined_barrel_shifter
